// File: rtl/cpu_bus_bridge_pkg.sv
// Shared state encodings, bus command layout and the KSEG address map for
// the CPU-to-SRAM-bus bridge.
package cpu_bus_bridge_pkg;

  localparam logic [2:0] BRG_IDLE   = 3'd0;
  localparam logic [2:0] BRG_D_ADDR = 3'd1;
  localparam logic [2:0] BRG_D_DATA = 3'd2;
  localparam logic [2:0] BRG_I_ADDR = 3'd3;
  localparam logic [2:0] BRG_I_DATA = 3'd4;

  typedef struct packed {
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_cmd_t;

  // kseg0/kseg1 (0x8000_0000..0xBFFF_FFFF) fold onto physical low memory.
  function automatic logic [31:0] kseg_map(input logic [31:0] addr, input logic enable);
    logic [31:0] mapped;
    mapped = addr;
    if (enable && (addr[31:30] == 2'b10)) mapped[31:29] = 3'b000;
    return mapped;
  endfunction

endpackage

// File: rtl/cpu_bus_bridge.sv
// Serialises the core's fetch and data SRAM ports onto one req/addr_ok/data_ok
// bus, data first, and stalls the pipeline until every presented access is done.
module cpu_bus_bridge
  import cpu_bus_bridge_pkg::*;
#(
  parameter int KSEG_MAP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_sram_en,
  input  logic [3:0]  inst_sram_wen,
  input  logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic        pipe_hold,
  output logic        stallreq,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata
);

  logic [2:0]  r_state;
  logic [2:0]  w_state_next;
  logic        r_d_done;
  logic        r_i_done;
  logic        r_d_wr;
  logic [31:0] r_data_rdata;
  logic [31:0] r_inst_rdata;
  logic        w_d_pend;
  logic        w_i_pend;
  logic        w_map_en;
  bus_cmd_t    w_cmd;
  logic        w_unused;

  // Fetches are read-only, so the fetch strobes carry no information.
  assign w_unused = ^inst_sram_wen;
  assign w_map_en = (KSEG_MAP != 0);

  assign w_d_pend = data_sram_en & ~r_d_done;
  assign w_i_pend = inst_sram_en & ~r_i_done;
  assign stallreq = ~rst & (w_d_pend | w_i_pend);

  // Payload is only driven in the ADDR states; it reads zero otherwise.
  always_comb begin
    w_cmd   = '0;
    bus_req = 1'b0;
    case (r_state)
      BRG_D_ADDR: begin
        bus_req     = 1'b1;
        w_cmd.wr    = |data_sram_wen;
        w_cmd.wstrb = data_sram_wen;
        w_cmd.addr  = kseg_map(data_sram_addr, w_map_en);
        w_cmd.wdata = data_sram_wdata;
      end
      BRG_I_ADDR: begin
        bus_req    = 1'b1;
        w_cmd.addr = kseg_map(inst_sram_addr, w_map_en);
      end
      default: ;
    endcase
  end

  assign bus_wr    = w_cmd.wr;
  assign bus_wstrb = w_cmd.wstrb;
  assign bus_addr  = w_cmd.addr;
  assign bus_wdata = w_cmd.wdata;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      BRG_IDLE: begin
        if (w_d_pend)      w_state_next = BRG_D_ADDR;
        else if (w_i_pend) w_state_next = BRG_I_ADDR;
      end
      BRG_D_ADDR: if (bus_addr_ok) w_state_next = BRG_D_DATA;
      BRG_D_DATA: if (bus_data_ok) w_state_next = w_i_pend ? BRG_I_ADDR : BRG_IDLE;
      BRG_I_ADDR: if (bus_addr_ok) w_state_next = BRG_I_DATA;
      BRG_I_DATA: if (bus_data_ok) w_state_next = BRG_IDLE;
      default:    w_state_next = BRG_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= BRG_IDLE;
      r_d_done     <= 1'b0;
      r_i_done     <= 1'b0;
      r_d_wr       <= 1'b0;
      r_data_rdata <= '0;
      r_inst_rdata <= '0;
    end else begin
      r_state <= w_state_next;
      // Latch the direction at acceptance so completion does not rely on wen.
      if ((r_state == BRG_D_ADDR) && bus_addr_ok) r_d_wr <= w_cmd.wr;
      if ((r_state == BRG_D_DATA) && bus_data_ok) begin
        r_d_done <= 1'b1;
        if (!r_d_wr) r_data_rdata <= bus_rdata;
      end
      if ((r_state == BRG_I_DATA) && bus_data_ok) begin
        r_i_done     <= 1'b1;
        r_inst_rdata <= bus_rdata;
      end
      // The pipeline advances on this edge; whatever it presents next is new.
      if (!stallreq && !pipe_hold) begin
        r_d_done <= 1'b0;
        r_i_done <= 1'b0;
      end
    end
  end

  assign data_sram_rdata = r_data_rdata;
  assign inst_sram_rdata = r_inst_rdata;

endmodule

// File: tb/tb_cpu_bus_bridge.sv
// Self-checking bench: a bus slave with configurable/random latency logs every
// accepted transaction; tests compare the log and outputs to expected behaviour.
module tb_cpu_bus_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_sram_en = 1'b0;
  logic [3:0]  inst_sram_wen = 4'h0;
  logic [31:0] inst_sram_addr = '0;
  logic        data_sram_en = 1'b0;
  logic [3:0]  data_sram_wen = 4'h0;
  logic [31:0] data_sram_addr = '0;
  logic [31:0] data_sram_wdata = '0;
  logic        pipe_hold = 1'b0;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;

  logic [31:0] inst_sram_rdata, data_sram_rdata;
  logic        stallreq, bus_req, bus_wr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr, bus_wdata;

  logic [31:0] pt_inst_rdata, pt_data_rdata;
  logic        pt_stallreq, pt_bus_req, pt_bus_wr;
  logic [3:0]  pt_bus_wstrb;
  logic [31:0] pt_bus_addr, pt_bus_wdata;

  always #5 clk = ~clk;

  cpu_bus_bridge #(.KSEG_MAP(1)) u_dut (
    .clk(clk), .rst(rst),
    .inst_sram_en(inst_sram_en), .inst_sram_wen(inst_sram_wen),
    .inst_sram_addr(inst_sram_addr), .inst_sram_rdata(inst_sram_rdata),
    .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_rdata(data_sram_rdata), .pipe_hold(pipe_hold), .stallreq(stallreq),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_wstrb(bus_wstrb), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
    .bus_rdata(bus_rdata)
  );

  cpu_bus_bridge #(.KSEG_MAP(0)) u_dut_pt (
    .clk(clk), .rst(rst),
    .inst_sram_en(inst_sram_en), .inst_sram_wen(inst_sram_wen),
    .inst_sram_addr(inst_sram_addr), .inst_sram_rdata(pt_inst_rdata),
    .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_rdata(pt_data_rdata), .pipe_hold(pipe_hold), .stallreq(pt_stallreq),
    .bus_req(pt_bus_req), .bus_wr(pt_bus_wr), .bus_wstrb(pt_bus_wstrb),
    .bus_addr(pt_bus_addr), .bus_wdata(pt_bus_wdata), .bus_addr_ok(bus_addr_ok),
    .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
  );

  typedef struct {
    logic        wr;
    logic [3:0]  strb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pt_addr;
    logic [31:0] rdata;
    int          ad;
    int          dd;
    bit          stable;
  } txn_t;

  txn_t txn_log[$];
  int   n_checks = 0;
  int   n_fail = 0;

  // Bus slave: addr_ok after ad wait cycles, data_ok dd cycles after acceptance.
  int          cfg_ad = 0, cfg_dd = 0;
  bit          rand_mode = 1'b0;
  bit          force_en = 1'b0;
  logic [31:0] force_val = '0;
  int          s_phase = 0, s_cnt = 0, s_ad = 0, s_dd = 0;
  logic [72:0] s_payload;
  bit          s_stable;
  txn_t        s_t;

  initial begin
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    bus_rdata   = '0;
    forever begin
      @(negedge clk);
      bus_addr_ok = 1'b0;
      bus_data_ok = 1'b0;
      if (rst) begin
        s_phase = 0;
        s_cnt   = 0;
      end else begin
        if (s_phase == 0 && bus_req === 1'b1) begin
          s_ad      = rand_mode ? int'($urandom_range(0, 3)) : cfg_ad;
          s_dd      = rand_mode ? int'($urandom_range(0, 3)) : cfg_dd;
          s_payload = {bus_wr, bus_wstrb, bus_addr, bus_wdata};
          s_stable  = 1'b1;
          s_cnt     = 0;
          s_phase   = 1;
        end
        if (s_phase == 1) begin
          if (bus_req !== 1'b1 || {bus_wr, bus_wstrb, bus_addr, bus_wdata} !== s_payload)
            s_stable = 1'b0;
          if (s_cnt < s_ad) begin
            s_cnt++;
          end else begin
            s_t.wr = bus_wr; s_t.strb = bus_wstrb; s_t.addr = bus_addr;
            s_t.wdata = bus_wdata; s_t.pt_addr = pt_bus_addr; s_t.rdata = '0;
            s_t.ad = s_ad; s_t.dd = s_dd; s_t.stable = s_stable;
            txn_log.push_back(s_t);
            bus_addr_ok = 1'b1;
            s_cnt   = 0;
            s_phase = 2;
          end
        end else if (s_phase == 2) begin
          if (s_cnt < s_dd) begin
            s_cnt++;
          end else begin
            bus_rdata = force_en ? force_val : $urandom;
            txn_log[txn_log.size()-1].rdata = bus_rdata;
            bus_data_ok = 1'b1;
            s_phase = 0;
          end
        end
      end
    end
  end

  function automatic logic [31:0] ref_map(input logic [31:0] a);
    if (a >= 32'h8000_0000 && a < 32'hC000_0000) return a & 32'h1FFF_FFFF;
    return a;
  endfunction

  // Presents one pipeline step's requests and counts cycles with stallreq high.
  task automatic run_step(input bit den, input logic [3:0] dwen, input logic [31:0] daddr,
                          input logic [31:0] dwdata, input bit ien, input logic [31:0] iaddr,
                          output int stall_cycles, output int first_txn);
    @(posedge clk); #1;
    data_sram_en = den; data_sram_wen = dwen; data_sram_addr = daddr;
    data_sram_wdata = dwdata; inst_sram_en = ien; inst_sram_addr = iaddr;
    inst_sram_wen = 4'($urandom);
    first_txn = txn_log.size();
    stall_cycles = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (stallreq !== 1'b1) break;
      stall_cycles++;
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    data_sram_en = 1'b0; inst_sram_en = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; data_sram_en = 1'b0; inst_sram_en = 1'b0; pipe_hold = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; data_sram_en = 1'b1; inst_sram_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (stallreq !== 1'b0) begin n_fail++; $display("FAIL reset_stallreq: got %b want 0", stallreq); end
    n_checks++;
    if ({bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata} !== 70'd0) begin
      n_fail++; $display("FAIL reset_bus: req=%b wr=%b strb=%h addr=%h wdata=%h want all 0",
                         bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata);
    end
    n_checks++;
    if ({data_sram_rdata, inst_sram_rdata} !== 64'd0) begin
      n_fail++; $display("FAIL reset_rdata: d=%h i=%h want 0", data_sram_rdata, inst_sram_rdata);
    end
    #1 data_sram_en = 1'b0; inst_sram_en = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    $display("reset: done");
  endtask

  task automatic test_single_read();
    int st, ft;
    rand_mode = 1'b0; cfg_ad = 0; cfg_dd = 0; force_en = 1'b1; force_val = 32'h2408_0001;
    run_step(1'b0, 4'h0, '0, '0, 1'b1, 32'hBFC0_0000, st, ft);
    force_en = 1'b0;
    n_checks++;
    if (st !== 3) begin n_fail++; $display("FAIL single_stall: got %0d want 3", st); end
    n_checks++;
    if (txn_log.size() - ft !== 1) begin
      n_fail++; $display("FAIL single_count: got %0d want 1", txn_log.size() - ft);
    end else begin
      n_checks++;
      if ({txn_log[ft].wr, txn_log[ft].strb, txn_log[ft].addr} !== {1'b0, 4'h0, 32'h1FC0_0000}) begin
        n_fail++; $display("FAIL single_txn: wr=%b strb=%h addr=%h want 0 0 1fc00000",
                           txn_log[ft].wr, txn_log[ft].strb, txn_log[ft].addr);
      end
    end
    n_checks++;
    if (inst_sram_rdata !== 32'h2408_0001) begin
      n_fail++; $display("FAIL single_rdata: got %h want 24080001", inst_sram_rdata);
    end
    $display("single read: addr bfc00000 stall=%0d rdata=%h", st, inst_sram_rdata);
    idle();
  endtask

  task automatic test_data_and_fetch();
    int st, ft;
    rand_mode = 1'b0; cfg_ad = 0; cfg_dd = 0;
    run_step(1'b1, 4'hF, 32'h8000_0010, 32'hDEAD_BEEF, 1'b1, 32'hBFC0_0004, st, ft);
    n_checks++;
    if (st !== 5) begin n_fail++; $display("FAIL both_stall: got %0d want 5", st); end
    n_checks++;
    if (txn_log.size() - ft !== 2) begin
      n_fail++; $display("FAIL both_count: got %0d want 2", txn_log.size() - ft);
    end else begin
      n_checks++;
      if ({txn_log[ft].wr, txn_log[ft].strb, txn_log[ft].addr, txn_log[ft].wdata} !==
          {1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF}) begin
        n_fail++; $display("FAIL both_first_write: wr=%b strb=%h addr=%h wdata=%h want 1 f 00000010 deadbeef",
                           txn_log[ft].wr, txn_log[ft].strb, txn_log[ft].addr, txn_log[ft].wdata);
      end
      n_checks++;
      if ({txn_log[ft+1].wr, txn_log[ft+1].strb, txn_log[ft+1].addr} !== {1'b0, 4'h0, 32'h1FC0_0004}) begin
        n_fail++; $display("FAIL both_second_read: wr=%b strb=%h addr=%h want 0 0 1fc00004",
                           txn_log[ft+1].wr, txn_log[ft+1].strb, txn_log[ft+1].addr);
      end
      n_checks++;
      if (inst_sram_rdata !== txn_log[ft+1].rdata) begin
        n_fail++; $display("FAIL both_inst_rdata: got %h want %h", inst_sram_rdata, txn_log[ft+1].rdata);
      end
    end
    n_checks++;
    if (data_sram_rdata !== 32'h0) begin
      n_fail++; $display("FAIL both_store_keeps_rdata: got %h want 0", data_sram_rdata);
    end
    $display("data+fetch: store 80000010 + fetch bfc00004 stall=%0d", st);
    idle();
  endtask

  task automatic test_backpressure();
    int st, ft;
    rand_mode = 1'b0; cfg_ad = 4; cfg_dd = 0;
    run_step(1'b1, 4'h0, 32'h9000_0100, 32'h1234_5678, 1'b0, '0, st, ft);
    cfg_ad = 0;
    n_checks++;
    if (st !== 7) begin n_fail++; $display("FAIL bp_stall: got %0d want 7", st); end
    n_checks++;
    if (txn_log.size() - ft !== 1) begin
      n_fail++; $display("FAIL bp_count: got %0d want 1", txn_log.size() - ft);
    end else begin
      n_checks++;
      if ({txn_log[ft].stable, txn_log[ft].ad} !== {1'b1, 32'd4}) begin
        n_fail++; $display("FAIL bp_hold: stable=%b wait=%0d want 1 4", txn_log[ft].stable, txn_log[ft].ad);
      end
      n_checks++;
      if ({txn_log[ft].wr, txn_log[ft].addr, txn_log[ft].wdata} !== {1'b0, 32'h1000_0100, 32'h1234_5678}) begin
        n_fail++; $display("FAIL bp_payload: wr=%b addr=%h wdata=%h want 0 10000100 12345678",
                           txn_log[ft].wr, txn_log[ft].addr, txn_log[ft].wdata);
      end
      n_checks++;
      if (data_sram_rdata !== txn_log[ft].rdata) begin
        n_fail++; $display("FAIL bp_rdata: got %h want %h", data_sram_rdata, txn_log[ft].rdata);
      end
    end
    $display("backpressure: load 90000100 stall=%0d", st);
    idle();
  endtask

  task automatic test_pipe_hold();
    int st, ft;
    logic [31:0] rd;
    rand_mode = 1'b0; cfg_ad = 0; cfg_dd = 0;
    pipe_hold = 1'b1;
    run_step(1'b1, 4'h0, 32'h0000_2000, '0, 1'b0, '0, st, ft);
    rd = (txn_log.size() > ft) ? txn_log[ft].rdata : 32'hX;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if ({stallreq, bus_req, data_sram_rdata} !== {1'b0, 1'b0, rd}) begin
        n_fail++; $display("FAIL hold_cycle%0d: stall=%b req=%b rdata=%h want 0 0 %h",
                           k, stallreq, bus_req, data_sram_rdata, rd);
      end
    end
    @(posedge clk); #1 pipe_hold = 1'b0;
    @(posedge clk); #1 data_sram_en = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (txn_log.size() - ft !== 1) begin
      n_fail++; $display("FAIL hold_reissue: got %0d transactions want 1", txn_log.size() - ft);
    end
    n_checks++;
    if (data_sram_rdata !== rd) begin
      n_fail++; $display("FAIL hold_rdata: got %h want %h", data_sram_rdata, rd);
    end
    $display("pipe hold: load 00002000 stall=%0d txns=%0d", st, txn_log.size() - ft);
  endtask

  task automatic test_passthrough();
    int st, ft;
    rand_mode = 1'b0; cfg_ad = 0; cfg_dd = 0;
    run_step(1'b0, 4'h0, '0, '0, 1'b1, 32'hA000_0004, st, ft);
    n_checks++;
    if (txn_log.size() - ft !== 1) begin
      n_fail++; $display("FAIL pt_count: got %0d want 1", txn_log.size() - ft);
    end else begin
      n_checks++;
      if ({txn_log[ft].pt_addr, txn_log[ft].addr} !== {32'hA000_0004, 32'h0000_0004}) begin
        n_fail++; $display("FAIL pt_addr: unmapped=%h mapped=%h want a0000004 00000004",
                           txn_log[ft].pt_addr, txn_log[ft].addr);
      end
    end
    $display("passthrough: fetch a0000004 stall=%0d", st);
    idle();
  endtask

  task automatic test_reset_mid();
    int n0;
    bit seen;
    rand_mode = 1'b0; cfg_ad = 0; cfg_dd = 3;
    @(posedge clk); #1;
    data_sram_en = 1'b1; data_sram_wen = 4'h0; data_sram_addr = 32'h0000_3000;
    n0 = txn_log.size();
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #1;
      if (txn_log.size() > n0) begin seen = 1'b1; break; end
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL rmid_accept: got no acceptance want one within 20 cycles"); end
    @(posedge clk); #1;
    rst = 1'b1; data_sram_en = 1'b0;
    @(negedge clk);
    n_checks++;
    if (stallreq !== 1'b0) begin n_fail++; $display("FAIL rmid_stall_in_reset: got %b want 0", stallreq); end
    @(posedge clk); #1 rst = 1'b0;
    cfg_dd = 0;
    @(negedge clk);
    n_checks++;
    if ({bus_req, stallreq, data_sram_rdata, inst_sram_rdata} !== 66'd0) begin
      n_fail++; $display("FAIL rmid_after: req=%b stall=%b d=%h i=%h want all 0",
                         bus_req, stallreq, data_sram_rdata, inst_sram_rdata);
    end
    $display("reset mid-transaction: done");
  endtask

  task automatic test_random_back_to_back();
    int st, ft, n_exp, exp_st;
    bit den, ien;
    logic [3:0] dwen;
    logic [31:0] daddr, dwdata, iaddr, exp_d, exp_i;
    txn_t exp_q[$];
    txn_t e;
    do_reset();
    rand_mode = 1'b1;
    exp_d = '0; exp_i = '0;
    for (int s = 0; s < 40; s++) begin
      den = 1'($urandom_range(0, 1));
      ien = 1'($urandom_range(0, 1));
      dwen = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      daddr = {$urandom, 2'b00} >> 0;
      daddr[1:0] = 2'b00;
      dwdata = $urandom;
      iaddr = $urandom;
      iaddr[1:0] = 2'b00;
      exp_q.delete();
      if (den) begin
        e.wr = (dwen != 4'h0); e.strb = dwen; e.addr = ref_map(daddr); e.wdata = dwdata;
        exp_q.push_back(e);
      end
      if (ien) begin
        e.wr = 1'b0; e.strb = 4'h0; e.addr = ref_map(iaddr); e.wdata = '0;
        exp_q.push_back(e);
      end
      run_step(den, dwen, daddr, dwdata, ien, iaddr, st, ft);
      n_exp = exp_q.size();
      n_checks++;
      if (txn_log.size() - ft !== n_exp) begin
        n_fail++; $display("FAIL rnd%0d_count: got %0d want %0d", s, txn_log.size() - ft, n_exp);
        continue;
      end
      exp_st = (n_exp > 0) ? 1 : 0;
      for (int j = 0; j < n_exp; j++) begin
        exp_st += 2 + txn_log[ft+j].ad + txn_log[ft+j].dd;
        n_checks++;
        if ({txn_log[ft+j].wr, txn_log[ft+j].strb, txn_log[ft+j].addr, txn_log[ft+j].wdata} !==
            {exp_q[j].wr, exp_q[j].strb, exp_q[j].addr, exp_q[j].wdata}) begin
          n_fail++; $display("FAIL rnd%0d_txn%0d: got wr=%b strb=%h addr=%h wdata=%h want %b %h %h %h",
                             s, j, txn_log[ft+j].wr, txn_log[ft+j].strb, txn_log[ft+j].addr,
                             txn_log[ft+j].wdata, exp_q[j].wr, exp_q[j].strb, exp_q[j].addr, exp_q[j].wdata);
        end
      end
      if (den && dwen == 4'h0) exp_d = txn_log[ft].rdata;
      if (ien) exp_i = txn_log[ft + n_exp - 1].rdata;
      n_checks++;
      if (st !== exp_st) begin n_fail++; $display("FAIL rnd%0d_stall: got %0d want %0d", s, st, exp_st); end
      n_checks++;
      if ({data_sram_rdata, inst_sram_rdata} !== {exp_d, exp_i}) begin
        n_fail++; $display("FAIL rnd%0d_rdata: got d=%h i=%h want d=%h i=%h",
                           s, data_sram_rdata, inst_sram_rdata, exp_d, exp_i);
      end
      $display("step %0d: den=%b wen=%h daddr=%h ien=%b iaddr=%h stall=%0d",
               s, den, dwen, daddr, ien, iaddr, st);
    end
    rand_mode = 1'b0;
    idle();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_data_and_fetch();
    test_backpressure();
    test_pipe_hold();
    test_passthrough();
    test_reset_mid();
    test_random_back_to_back();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_bus_bridge.md
# cpu_bus_bridge

- Sits between the CPU core's SRAM-style fetch and data ports and one shared SRAM-like memory bus. The bus uses a `req`/`addr_ok`/`data_ok` handshake.
- Serialises instruction and data accesses onto the bus, with data taking priority.
- Captures read data and raises a stall request until every access presented this cycle has completed.
- The stall request is ORed into the CTRL stall request, so the core pipeline needs no change.

## Interface
Parameters:
- `KSEG_MAP`, default 1: when 1, addresses 0x8000_0000–0xBFFF_FFFF have bits [31:29] cleared before issue; when 0, addresses pass unchanged.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `inst_sram_en` in 1: fetch request.
- `inst_sram_wen` in 4: ignored; fetches are read-only.
- `inst_sram_addr` in 32: fetch address.
- `inst_sram_rdata` out 32: captured fetch data.
- `data_sram_en` in 1: data request.
- `data_sram_wen` in 4: byte write strobes; 0 means read.
- `data_sram_addr` in 32: data address.
- `data_sram_wdata` in 32: store data.
- `data_sram_rdata` out 32: captured load data.
- `pipe_hold` in 1: pipeline is held by another stall source (`stallreq_for_ex`).
- `stallreq` out 1: hold the pipeline.
- `bus_req` out 1: bus request.
- `bus_wr` out 1: 1 = write.
- `bus_wstrb` out 4: byte strobes.
- `bus_addr` out 32: bus address.
- `bus_wdata` out 32: bus write data.
- `bus_addr_ok` in 1: request accepted.
- `bus_data_ok` in 1: response or write completion.
- `bus_rdata` in 32: read data.

## Operation
- **State machine.** States are IDLE, D_ADDR, D_DATA, I_ADDR, I_DATA.
- **Done flags.** `d_done` and `i_done` are registers that mark accesses completed for the current pipeline step.
- **Pending requests.**
  - `d_pend` = `data_sram_en & ~d_done`.
  - `i_pend` = `inst_sram_en & ~i_done`.
- **Stall request.** `stallreq` = `~rst & (d_pend | i_pend)`; it is combinational.
- **IDLE.**
  - If `d_pend`, go to D_ADDR.
  - Else if `i_pend`, go to I_ADDR.
  - Otherwise stay in IDLE.
- **D_ADDR.**
  - Drive `bus_req`=1.
  - Drive `bus_wr`=`|data_sram_wen`, `bus_wstrb`=`data_sram_wen`, `bus_addr`=mapped `data_sram_addr`, `bus_wdata`=`data_sram_wdata`.
  - Go to D_DATA on `bus_addr_ok`.
  - The core holds these inputs stable because `stallreq`=1.
- **D_DATA.**
  - Drive `bus_req`=0.
  - On `bus_data_ok`: set `d_done`. If it was a read, load `bus_rdata` into the `data_sram_rdata` register; writes leave that register unchanged.
  - Then go to I_ADDR if `i_pend`, else to IDLE.
- **I_ADDR / I_DATA.** Same as the data path, with `bus_wr`=0 and `bus_wstrb`=0. On completion, `i_done` is set, `inst_sram_rdata` is loaded, and the state goes to IDLE.
- **Flag clear.** On any edge where `stallreq`=0 and `pipe_hold`=0, clear `d_done` and `i_done`. The pipeline advances on that edge, so the next presented request is treated as new.
- **Flag hold.** While `pipe_hold`=1, the flags hold, so a held request is never reissued.
- **Read data.** The rdata registers hold their value until the next capture. The MEM stage samples `data_sram_rdata` in the cycle after release.
- **Outputs outside ADDR states.** `bus_addr`, `bus_wdata`, `bus_wstrb` and `bus_wr` are 0 whenever `bus_req`=0.

## Timing
- **Reset values.** State IDLE; `d_done`=`i_done`=0; both rdata registers 0; `bus_req`=0; all bus outputs 0; `stallreq`=0.
- **Reset mid-transaction.** Return to IDLE next edge and drop `bus_req`. The outstanding bus transaction is abandoned; the bus slave shares `rst`.
- **Minimum latency, single access.**
  - Request seen in cycle 0.
  - `bus_req` asserted in cycle 1.
  - With `addr_ok`=1 in cycle 1 and `data_ok`=1 in cycle 2, `stallreq` falls in cycle 3. That is 3 stalled cycles.
- **Both ports requesting.** Data is served first, then inst back-to-back with no IDLE cycle between. Minimum is 5 stalled cycles.
- **Bus handshake hold.** `bus_req` stays high, with stable payload, until `bus_addr_ok`.
- **Ignored inputs.** `bus_data_ok` is ignored outside the DATA states. `bus_addr_ok` is ignored while `bus_req`=0.
- **Outstanding transactions.** At most one transaction is outstanding.
- **`en` dropped mid-transaction.** This is illegal while `stallreq`=1. The bridge still completes the transaction, with no retry.

## Structure
- State encodings (`BRG_IDLE` … `BRG_I_DATA`, 3-bit) go in `lib/defines.vh` beside the existing bus-width macros.
- No sub-module. The KSEG address map is a small function used by both channels.
- The top level instantiates the bridge alongside `u_CTRL`; CTRL receives `stallreq_for_load | stallreq` from the bridge.

## Test plan
- **Single read.** `inst_sram_en`=1, addr 0xBFC0_0000; bus returns `addr_ok` immediately and `data_ok` one cycle later with 0x2408_0001.
  - Required: `bus_addr`=0x1FC0_0000.
  - Required: `stallreq` high cycles 0–2, low in cycle 3.
  - Required: `inst_sram_rdata`=0x2408_0001 from cycle 3.
- **Data and fetch together.** Store (wen 0xF, addr 0x8000_0010, wdata 0xDEADBEEF) plus a fetch.
  - Required: write transaction with `bus_wstrb`=0xF first, then the read.
  - Required: `stallreq` low only after both complete.
- **Bus back-pressure.** Hold `bus_addr_ok`=0 for 4 cycles.
  - Required: `bus_req` and payload stable for 4 cycles; no state advance.
- **Pipeline held by another source.** `pipe_hold`=1 for 3 cycles after completion.
  - Required: no reissue; exactly one bus transaction; rdata stable.
- **Reset during D_DATA.** Assert `rst`.
  - Required: next cycle state IDLE, `bus_req`=0, `stallreq`=0, rdata registers 0.
- **Passthrough map.** `KSEG_MAP`=0, addr 0xA000_0004.
  - Required: `bus_addr`=0xA000_0004 unchanged.
